// File: rtl/mux_nto1_rr_if.sv
// mux_nto1_rr_if: channel inputs, select controls and output handshake of mux_nto1_rr.
// out_parity exists only when MUX_NTO1_PARITY_EN is defined.
interface mux_nto1_rr_if #(parameter int WIDTH = 8, parameter int CHANNELS = 4);
   localparam int SEL_W = $clog2(CHANNELS);
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [SEL_W-1:0]          out_chan;
`ifdef MUX_NTO1_PARITY_EN
   logic                      out_parity;
   modport master (output in_data, in_valid, mode, sel, out_ready,
                   input in_ready, out_data, out_valid, out_chan, out_parity);
   modport slave  (input in_data, in_valid, mode, sel, out_ready,
                   output in_ready, out_data, out_valid, out_chan, out_parity);
`else
   modport master (output in_data, in_valid, mode, sel, out_ready,
                   input in_ready, out_data, out_valid, out_chan);
   modport slave  (input in_data, in_valid, mode, sel, out_ready,
                   output in_ready, out_data, out_valid, out_chan);
`endif
endinterface

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: registered N:1 stream mux with fixed-select and round-robin modes.
// Define MUX_NTO1_PARITY_EN to add a registered even-parity output.
module mux_nto1_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic         clk,
   input logic         rst_n,
   mux_nto1_rr_if.slave bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t              state, state_nx;
   logic [SEL_W-1:0]    rr_ptr, rr_idx, cand, pick;
   logic                pick_ok, load_en, xfer;
   logic [CHANNELS-1:0] ready;
   logic [WIDTH-1:0]    word;
   // Descending scan so the valid channel closest to rr_ptr wins.
   always_comb begin
      rr_idx = rr_ptr;
      cand = rr_ptr;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         cand = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
         if (bus.in_valid[cand]) rr_idx = cand;
      end
   end
   assign pick    = bus.mode ? rr_idx : bus.sel;
   assign pick_ok = bus.mode | (32'(bus.sel) < CHANNELS);
   assign load_en = (state == EMPTY) | bus.out_ready;
   always_comb begin
      ready = '0;
      word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ready[i] = rst_n & load_en & pick_ok & (pick == SEL_W'(i));
         if (pick == SEL_W'(i)) word = bus.in_data[i*WIDTH +: WIDTH];
      end
   end
   assign xfer          = |(bus.in_valid & ready);
   assign bus.in_ready  = ready;
   assign bus.out_valid = (state == FULL);
   always_comb begin
      state_nx = xfer ? FULL : (bus.out_ready ? EMPTY : state);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_data <= '0;
         bus.out_chan <= '0;
         rr_ptr       <= '0;
      end else if (xfer) begin
         bus.out_data <= word;
         bus.out_chan <= pick;
         if (bus.mode) rr_ptr <= (32'(pick) == CHANNELS - 1) ? '0 : pick + SEL_W'(1);
      end
   end
`ifdef MUX_NTO1_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    bus.out_parity <= 1'b0;
      else if (xfer) bus.out_parity <= ^word;
   end
`endif
endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed stimulus with an abstract stream model checked every cycle.
module tb_mux_nto1_rr;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   mux_nto1_rr_if #(.WIDTH(8), .CHANNELS(4)) bus ();
   mux_nto1_rr #(.WIDTH(8), .CHANNELS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   logic       exp_valid = 1'b0;
   logic [7:0] exp_data = 8'h00;
   int         exp_chan = 0;
   int         exp_ptr = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
      end
   endtask
   // The one channel that may be accepted this cycle, as a one-hot mask.
   function automatic logic [3:0] model_ready();
      logic [3:0] r = 4'b0000;
      if (!rst_n || (exp_valid && !bus.out_ready)) return r;
      if (!bus.mode) return (int'(bus.sel) < 4) ? 4'(1 << bus.sel) : 4'b0000;
      for (int off = 0; off < 4; off++)
         if (bus.in_valid[(exp_ptr + off) % 4]) return 4'(1 << ((exp_ptr + off) % 4));
      return 4'(1 << exp_ptr);
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_valid = 1'b0; exp_data = 8'h00; exp_chan = 0; exp_ptr = 0;
      end else begin
         logic [3:0] r;
         r = model_ready();
         if ((r & bus.in_valid) != 4'b0000) begin
            for (int c = 0; c < 4; c++)
               if (r[c]) begin
                  exp_data = bus.in_data[c*8 +: 8];
                  exp_chan = c;
                  if (bus.mode) exp_ptr = (c + 1) % 4;
               end
            exp_valid = 1'b1;
         end else if (bus.out_ready) exp_valid = 1'b0;
      end
   end
   always @(negedge clk) begin
      chk("model in_ready", 32'(bus.in_ready), 32'(model_ready()));
      chk("model out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("model out_data", 32'(bus.out_data), 32'(exp_data));
      chk("model out_chan", 32'(bus.out_chan), 32'(exp_chan));
`ifdef MUX_NTO1_PARITY_EN
      chk("model out_parity", 32'(bus.out_parity), 32'(^exp_data));
`endif
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.in_data = '0; bus.in_valid = '0; bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      // Fixed select
      bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      bus.in_data = {8'h04, 8'hA5, 8'h02, 8'h01};
      #1 chk("fixed in_ready sel2", 32'(bus.in_ready), 32'h4);
      step();
      chk("fixed out_data", 32'(bus.out_data), 32'hA5);
      chk("fixed out_chan", 32'(bus.out_chan), 32'd2);
      bus.sel = 2'd3;
      #1 chk("fixed in_ready sel3", 32'(bus.in_ready), 32'h8);
      step();
      chk("fixed sel3 data", 32'(bus.out_data), 32'h04);
      // Round-robin fairness from rr_ptr=0
      bus.mode = 1'b1; bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr chan", 32'(bus.out_chan), 32'(i % 4));
         chk("rr data", 32'(bus.out_data), 32'(8'h10 + i % 4));
      end
      step();
      chk("rr chan ptr2 setup", 32'(bus.out_chan), 32'd1);
      // Round-robin skip with rr_ptr=2
      bus.in_valid = 4'b1010;
      step(); chk("skip ch3", 32'(bus.out_chan), 32'd3);
      step(); chk("skip ch1", 32'(bus.out_chan), 32'd1);
      step(); chk("skip ch3 again", 32'(bus.out_chan), 32'd3);
      // Backpressure
      bus.mode = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'b0001; bus.in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
      step();
      chk("bp load", 32'(bus.out_data), 32'h3C);
      bus.out_ready = 1'b0; bus.in_data = {8'h00, 8'h00, 8'h00, 8'h99};
      #1 chk("bp in_ready", 32'(bus.in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp hold data", 32'(bus.out_data), 32'h3C);
         chk("bp hold valid", 32'(bus.out_valid), 32'd1);
         chk("bp hold in_ready", 32'(bus.in_ready), 32'h0);
      end
      bus.out_ready = 1'b1; bus.in_valid = 4'b0000;
      step();
      chk("bp drain", 32'(bus.out_valid), 32'd0);
`ifdef MUX_NTO1_PARITY_EN
      bus.in_valid = 4'b0001; bus.in_data = {8'h00, 8'h00, 8'h00, 8'h07};
      step(); chk("parity 07", 32'(bus.out_parity), 32'd1);
      bus.in_data = {8'h00, 8'h00, 8'h00, 8'h03};
      step(); chk("parity 03", 32'(bus.out_parity), 32'd0);
`endif
      // Asynchronous reset while holding a word
      bus.sel = 2'd1; bus.in_valid = 4'b0010; bus.in_data = {8'h00, 8'h00, 8'h55, 8'h00}; bus.out_ready = 1'b0;
      step();
      chk("pre-reset valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data", 32'(bus.out_data), 32'd0);
      chk("reset out_chan", 32'(bus.out_chan), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd0);
      step();
      rst_n = 1'b1;
      step(); step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
